// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the single-ported memory arbiter that sits between
// the instruction-fetch stage and the MEM stage of the pipeline.
//   ADDR_W / DATA_W : width of the shared memory address and data buses
//   arb_state_t     : arbiter FSM encoding (IDLE, GRANT_IF, GRANT_MEM)
//   mem_wins        : arbitration decision between the two requesters
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IF  = 2'd1,
    GRANT_MEM = 2'd2
  } arb_state_t;

  // MEM has priority, except when fetch has already been passed over the
  // maximum number of times in a row.
  function automatic logic mem_wins(input logic if_req,
                                    input logic mem_req,
                                    input logic if_starved);
    return mem_req && !(if_req && if_starved);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates a single non-pipelined memory port between instruction fetch
// (IF) and the MEM stage. One access is outstanding at a time; a granted
// command is held on port_* until port_ready, then the winner sees a
// one-cycle valid pulse with the captured read data.
//
// Parameters
//   STARVE_LIMIT : max consecutive MEM grants while a fetch is pending
//   WAIT_LIMIT   : max wait cycles on the port before a timeout is declared
// Ports
//   clk, rst_n                      : clock, synchronous active-low reset
//   if_req, if_addr                 : fetch read request
//   mem_req, mem_we, mem_addr,
//   mem_wdata                       : MEM-stage load/store request
//   port_ready, port_rdata          : shared memory completion / read data
//   port_req, port_we, port_addr,
//   port_wdata                      : registered command to shared memory
//   if_valid/if_rdata,
//   mem_valid/mem_rdata             : completion pulses and held read data
//   stall_F, stall_M                : pipeline stalls while a request waits
//   timeout                         : sticky port-timeout error flag
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int WAIT_LIMIT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              port_ready,
  input  logic [DATA_W-1:0] port_rdata,
  output logic              port_req,
  output logic              port_we,
  output logic [ADDR_W-1:0] port_addr,
  output logic [DATA_W-1:0] port_wdata,
  output logic              if_valid,
  output logic              mem_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_F,
  output logic              stall_M,
  output logic              timeout
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;

  // Saturating increment of the fetch-starvation counter.
  function automatic logic [SW-1:0] starve_sat_inc(input logic [SW-1:0] c);
    return (c == SW'(STARVE_LIMIT)) ? c : c + SW'(1);
  endfunction

  assign stall_F = if_req & ~if_valid;
  assign stall_M = mem_req & ~mem_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      timeout    <= 1'b0;
      port_req   <= 1'b0;
      port_we    <= 1'b0;
      port_addr  <= '0;
      port_wdata <= '0;
      if_valid   <= 1'b0;
      mem_valid  <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          // During a valid pulse the requester still shows its old request;
          // skip arbitration for that one cycle so it is not served twice.
          if (!if_valid && !mem_valid && (if_req || mem_req)) begin
            port_req <= 1'b1;
            if (mem_wins(if_req, mem_req, starve_cnt == SW'(STARVE_LIMIT))) begin
              state      <= GRANT_MEM;
              port_we    <= mem_we;
              port_addr  <= mem_addr;
              port_wdata <= mem_wdata;
              if (if_req) begin
                starve_cnt <= starve_sat_inc(starve_cnt);
              end
            end else begin
              state      <= GRANT_IF;
              port_we    <= 1'b0;
              port_addr  <= if_addr;
              port_wdata <= '0;
              starve_cnt <= '0;
            end
          end
        end

        GRANT_IF, GRANT_MEM: begin
          if (port_ready) begin
            state    <= IDLE;
            port_req <= 1'b0;
            port_we  <= 1'b0;
            if (state == GRANT_IF) begin
              if_rdata <= port_rdata;
              if_valid <= 1'b1;
            end else begin
              // Stores complete without touching the held load data.
              mem_valid <= 1'b1;
              if (!port_we) begin
                mem_rdata <= port_rdata;
              end
            end
          end else if (wait_cnt == WW'(WAIT_LIMIT - 1)) begin
            // Give up on this access: no valid pulse, requester will be
            // re-arbitrated from IDLE if it is still asking.
            wait_cnt <= WW'(WAIT_LIMIT);
            timeout  <= 1'b1;
            state    <= IDLE;
            port_req <= 1'b0;
            port_we  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        port_ready = 1'b0;
  logic [31:0] port_rdata = '0;
  logic        port_req, port_we;
  logic [31:0] port_addr, port_wdata;
  logic        if_valid, mem_valid;
  logic [31:0] if_rdata, mem_rdata;
  logic        stall_F, stall_M, timeout;

  mem_port_arbiter #(.STARVE_LIMIT(3), .WAIT_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .port_ready(port_ready), .port_rdata(port_rdata),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_wdata(port_wdata),
    .if_valid(if_valid), .mem_valid(mem_valid), .if_rdata(if_rdata), .mem_rdata(mem_rdata),
    .stall_F(stall_F), .stall_M(stall_M), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mdl_mem_rdata = '0;
  int          ws_cfg = 0;
  int          ws_cnt = 0;
  bit          mem_en = 1'b1;
  bit          force_ready = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C02_0004;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic push_exp(input bit is_if, input logic [31:0] rdata);
    exp_t e;
    e.is_if = is_if;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Shared memory model: completes after ws_cfg wait states.
  always @(negedge clk) begin
    if (force_ready) begin
      port_ready = 1'b1;
      port_rdata = 32'hBAD0_BAD0;
    end else if (mem_en && rst_n && port_req) begin
      if (ws_cnt >= ws_cfg) begin
        port_ready = 1'b1;
        port_rdata = mem_word(port_addr);
        ws_cnt     = 0;
      end else begin
        port_ready = 1'b0;
        port_rdata = 32'h0BAD_F00D;
        ws_cnt++;
      end
    end else begin
      port_ready = 1'b0;
      port_rdata = 32'h0BAD_F00D;
      ws_cnt     = 0;
    end
  end

  // Scoreboard: every valid pulse must match the next expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (if_valid || mem_valid)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: if_valid=%0b mem_valid=%0b, required no pulse", if_valid, mem_valid);
      end else begin
        e = sb.pop_front();
        if (if_valid !== e.is_if || mem_valid !== !e.is_if) begin
          miscompares++;
          $display("FAIL grant_order: if_valid=%0b mem_valid=%0b, required if_valid=%0b", if_valid, mem_valid, e.is_if);
        end else if (e.is_if && if_rdata !== e.rdata) begin
          miscompares++;
          $display("FAIL if_rdata: got %h, required %h", if_rdata, e.rdata);
        end else if (!e.is_if && mem_rdata !== e.rdata) begin
          miscompares++;
          $display("FAIL mem_rdata: got %h, required %h", mem_rdata, e.rdata);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({port_req, port_we, if_valid, mem_valid, timeout, stall_F, stall_M} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, required 0000000", {port_req, port_we, if_valid, mem_valid, timeout, stall_F, stall_M});
    end
    vectors++;
    if ({port_addr, port_wdata, if_rdata, mem_rdata} !== 128'b0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h %h %h, required all 0", port_addr, port_wdata, if_rdata, mem_rdata);
    end
    vectors++;
    if (dut.state !== IDLE || dut.starve_cnt !== '0 || dut.wait_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d starve=%0d wait=%0d, required 0 0 0", dut.state, dut.starve_cnt, dut.wait_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_mem_rdata = '0;
  endtask

  task automatic test_fetch();
    ws_cfg  = 0;
    if_req  = 1'b1;
    if_addr = 32'h40;
    push_exp(1'b1, 32'h8C02_0004);
    @(negedge clk);  // cycle 1
    vectors++;
    if (stall_F !== 1'b1 || port_req !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_c1: stall_F=%0b port_req=%0b, required 1 0", stall_F, port_req);
    end
    @(negedge clk);  // cycle 2: grant
    vectors++;
    if (stall_F !== 1'b1 || port_req !== 1'b1 || port_we !== 1'b0 || port_addr !== 32'h40) begin
      miscompares++;
      $display("FAIL fetch_c2: stall_F=%0b req=%0b we=%0b addr=%h, required 1 1 0 00000040", stall_F, port_req, port_we, port_addr);
    end
    @(negedge clk);  // cycle 3: valid
    vectors++;
    if (if_valid !== 1'b1 || stall_F !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_c3: if_valid=%0b stall_F=%0b, required 1 0", if_valid, stall_F);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (port_req !== 1'b0 || if_valid !== 1'b0 || if_rdata !== 32'h8C02_0004) begin
      miscompares++;
      $display("FAIL fetch_after: port_req=%0b if_valid=%0b if_rdata=%h, required 0 0 8c020004", port_req, if_valid, if_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_mem_load(input logic [31:0] a, input int ws);
    bit seen = 1'b0;
    ws_cfg   = ws;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = a;
    push_exp(1'b0, mem_word(a));
    mdl_mem_rdata = mem_word(a);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_valid) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL load_wait: mem_valid=0 after 40 cycles, required pulse");
    end
    @(posedge clk); #1;
    mem_req = 1'b0;
  endtask

  task automatic test_load();
    do_mem_load(32'h200, 1);
  endtask

  task automatic test_store();
    ws_cfg    = 2;
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h100;
    mem_wdata = 32'hDEAD_BEEF;
    push_exp(1'b0, mdl_mem_rdata);
    @(negedge clk);  // cycle 1
    vectors++;
    if (stall_M !== 1'b1) begin
      miscompares++;
      $display("FAIL store_c1: stall_M=%0b, required 1", stall_M);
    end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      vectors++;
      if (port_req !== 1'b1 || port_we !== 1'b1 || port_addr !== 32'h100 || port_wdata !== 32'hDEAD_BEEF || mem_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL store_c%0d: req=%0b we=%0b addr=%h wdata=%h valid=%0b, required 1 1 00000100 deadbeef 0",
                 c, port_req, port_we, port_addr, port_wdata, mem_valid);
      end
    end
    @(negedge clk);  // cycle 5
    vectors++;
    if (mem_valid !== 1'b1 || stall_M !== 1'b0) begin
      miscompares++;
      $display("FAIL store_c5: mem_valid=%0b stall_M=%0b, required 1 0", mem_valid, stall_M);
    end
    @(posedge clk); #1;
    mem_req = 1'b0;
    mem_we  = 1'b0;
  endtask

  task automatic test_idle_ready();
    force_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (port_req !== 1'b0 || mem_rdata !== mdl_mem_rdata || if_rdata !== 32'h8C02_0004) begin
        miscompares++;
        $display("FAIL idle_ready: port_req=%0b mem_rdata=%h if_rdata=%h, required 0 %h 8c020004", port_req, mem_rdata, if_rdata, mdl_mem_rdata);
      end
    end
    @(posedge clk); #1;
    force_ready = 1'b0;
  endtask

  task automatic test_contention();
    int n = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_mem_rdata = mem_word(32'h300);
    ws_cfg   = 0;
    if_req   = 1'b1;
    if_addr  = 32'h40;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h300;
    push_exp(1'b0, mem_word(32'h300));
    push_exp(1'b0, mem_word(32'h300));
    push_exp(1'b0, mem_word(32'h300));
    push_exp(1'b1, 32'h8C02_0004);
    push_exp(1'b0, mem_word(32'h300));
    for (int i = 0; i < 60 && n < 5; i++) begin
      @(negedge clk);
      if (if_valid || mem_valid) n++;
    end
    @(posedge clk); #1;
    if_req  = 1'b0;
    mem_req = 1'b0;
    vectors++;
    if (n != 5) begin
      miscompares++;
      $display("FAIL contention_count: got %0d completions, required 5", n);
    end
    vectors++;
    if (dut.starve_cnt !== 2'd1) begin
      miscompares++;
      $display("FAIL starve_cnt: got %0d, required 1", dut.starve_cnt);
    end
  endtask

  task automatic test_timeout();
    bit granted = 1'b0;
    mem_en   = 1'b0;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h400;
    for (int i = 0; i < 5 && !granted; i++) begin
      @(negedge clk);
      if (port_req) granted = 1'b1;
    end
    vectors++;
    if (!granted) begin
      miscompares++;
      $display("FAIL timeout_grant: port_req=0, required 1");
    end
    repeat (14) @(negedge clk);  // wait cycle 15
    vectors++;
    if (timeout !== 1'b0 || port_req !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: timeout=%0b port_req=%0b, required 0 1", timeout, port_req);
    end
    @(negedge clk);
    mem_req = 1'b0;
    vectors++;
    if (timeout !== 1'b1 || port_req !== 1'b0 || dut.state !== IDLE) begin
      miscompares++;
      $display("FAIL timeout_set: timeout=%0b port_req=%0b state=%0d, required 1 0 0", timeout, port_req, dut.state);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: got %0b, required 1", timeout);
    end
    @(posedge clk); #1;
    mem_en = 1'b1;
    do_mem_load(32'h400, 0);
    @(negedge clk);
    vectors++;
    if (timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_after_retry: got %0b, required 1", timeout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit granted = 1'b0;
    mem_en   = 1'b0;
    if_req   = 1'b1;
    if_addr  = 32'h40;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h500;
    for (int i = 0; i < 5 && !granted; i++) begin
      @(negedge clk);
      if (port_req) granted = 1'b1;
    end
    vectors++;
    if (!granted || dut.state !== GRANT_MEM || dut.starve_cnt !== 2'd2 || mem_rdata !== mdl_mem_rdata) begin
      miscompares++;
      $display("FAIL mid_pre: req=%0b state=%0d starve=%0d mem_rdata=%h, required 1 2 2 %h",
               port_req, dut.state, dut.starve_cnt, mem_rdata, mdl_mem_rdata);
    end
    @(posedge clk); #1;
    rst_n   = 1'b0;
    if_req  = 1'b0;
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_mem_rdata = '0;
    @(negedge clk);
    vectors++;
    if (port_req !== 1'b0 || mem_valid !== 1'b0 || mem_rdata !== 32'h0 || dut.starve_cnt !== '0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: req=%0b valid=%0b rdata=%h starve=%0d timeout=%0b, required 0 0 0 0 0",
               port_req, mem_valid, mem_rdata, dut.starve_cnt, timeout);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    mem_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_idle_ready();
    test_contention();
    test_timeout();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d completions outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
